// File: rtl/icache_pkg.sv
// Shared types, geometry and address-slicing helpers for the instruction-cache
// lookup/refill controller.
package icache_pkg;

  localparam int ADDR_W   = 18;
  localparam int TAG_W    = 7;
  localparam int IDX_W    = 7;
  localparam int SETS     = 1 << IDX_W;
  localparam int WORDS    = 4;
  localparam int DATA_W   = 32;
  localparam int THREAD_W = 2;
  localparam int OFF_W    = ADDR_W - TAG_W - IDX_W;
  localparam int BEAT_W   = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_MEM_REQ = 3'd2,
    S_REFILL  = 3'd3,
    S_UPDATE  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [THREAD_W-1:0] thread;
  } fetch_req_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_valid_array.sv
// Per-set valid flops: async reset, synchronous clear-all, single-set write,
// combinational single-set read.
module icache_valid_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             nReset,
  input  logic             clear_all,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid
);

  logic [SETS-1:0] valid_q;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)                                   valid_q[s] <= 1'b0;
      else if (clear_all)                            valid_q[s] <= 1'b0;
      else if (set_en && (set_idx == IDX_W'(s)))     valid_q[s] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/icache_lookup_ctrl.sv
// Instruction-cache lookup and line-refill controller in front of the tag
// memory; one request outstanding except for the hit/accept overlap.
module icache_lookup_ctrl
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [THREAD_W-1:0]   req_thread,
  output logic                  req_ready,
  output logic                  tag_rd_en,
  output logic [IDX_W-1:0]      tag_rd_index,
  input  logic [TAG_W-1:0]      tag_cmp,
  output logic                  tag_wr_en,
  output logic [IDX_W-1:0]      tag_wr_index,
  output logic [TAG_W-1:0]      tag_wr_tag,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic                  data_wr_en,
  output logic [IDX_W+BEAT_W-1:0] data_wr_index,
  output logic [DATA_W-1:0]     data_wr_data,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [ADDR_W-1:0]     resp_addr,
  output logic [THREAD_W-1:0]   resp_thread
);

  state_t              state_q, state_d;
  fetch_req_t          req_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                flush_pending_q;

  logic                rd_valid, hit, accept, flush_now, line_done;
  logic [TAG_W-1:0]    reg_tag;
  logic [IDX_W-1:0]    reg_idx;

  assign reg_tag   = get_tag(req_q.addr);
  assign reg_idx   = get_idx(req_q.addr);
  assign hit       = (state_q == S_COMPARE) && rd_valid && (tag_cmp == reg_tag);
  // The flush cycle is an IDLE cycle that accepts nothing, so the clear never
  // races a lookup of the set it is invalidating.
  assign flush_now = (state_q == S_IDLE) && flush_pending_q;
  assign req_ready = !flush_pending_q && ((state_q == S_IDLE) || hit);
  assign accept    = req_valid && req_ready;
  assign line_done = (state_q == S_REFILL) && mem_rsp_valid &&
                     (beat_q == BEAT_W'(WORDS-1));

  icache_valid_array u_valid (
    .clk       (clk),
    .nReset    (nReset),
    .clear_all (flush_now),
    .set_en    (state_q == S_UPDATE),
    .set_idx   (reg_idx),
    .rd_idx    (reg_idx),
    .rd_valid  (rd_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_COMPARE;
      S_COMPARE: if (!hit) state_d = S_MEM_REQ;
                 else if (!accept) state_d = S_IDLE;
      S_MEM_REQ: if (mem_req_ready) state_d = S_REFILL;
      S_REFILL:  if (line_done) state_d = S_UPDATE;
      S_UPDATE:  state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q         <= S_IDLE;
      req_q           <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) req_q <= '{addr: req_addr, thread: req_thread};
      if (state_q == S_MEM_REQ)                        beat_q <= '0;
      else if ((state_q == S_REFILL) && mem_rsp_valid) beat_q <= beat_q + 1'b1;
      // A pulse landing in the flush cycle itself re-arms the flush.
      if (flush)          flush_pending_q <= 1'b1;
      else if (flush_now) flush_pending_q <= 1'b0;
    end
  end

  // Tag read is issued in the accept cycle; nothing reads in UPDATE, so a
  // follow-on request to the same set sees the freshly written tag.
  assign tag_rd_en     = accept;
  assign tag_rd_index  = accept ? get_idx(req_addr) : '0;

  assign tag_wr_en     = (state_q == S_UPDATE);
  assign tag_wr_index  = tag_wr_en ? reg_idx : '0;
  assign tag_wr_tag    = tag_wr_en ? reg_tag : '0;

  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_addr  = mem_req_valid ? line_addr(req_q.addr) : '0;

  assign data_wr_en    = (state_q == S_REFILL) && mem_rsp_valid;
  assign data_wr_index = data_wr_en ? {reg_idx, beat_q} : '0;
  assign data_wr_data  = data_wr_en ? mem_rsp_data : '0;

  assign resp_valid    = hit || (state_q == S_RESP);
  assign resp_hit      = hit;
  assign resp_addr     = resp_valid ? req_q.addr : '0;
  assign resp_thread   = resp_valid ? req_q.thread : '0;

endmodule

// File: tb/tb_icache_lookup_ctrl.sv
// Self-checking bench: emulates tag memory and refill memory, checks against a
// set-level cache model (valid + tag per set).
module tb_icache_lookup_ctrl;
  import icache_pkg::*;

  logic                   clk = 1'b0;
  logic                   nReset;
  logic                   req_valid;
  logic [ADDR_W-1:0]      req_addr;
  logic [THREAD_W-1:0]    req_thread;
  logic                   req_ready;
  logic                   tag_rd_en;
  logic [IDX_W-1:0]       tag_rd_index;
  logic [TAG_W-1:0]       tag_cmp = '0;
  logic                   tag_wr_en;
  logic [IDX_W-1:0]       tag_wr_index;
  logic [TAG_W-1:0]       tag_wr_tag;
  logic                   mem_req_valid;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic                   mem_req_ready;
  logic                   mem_rsp_valid;
  logic [DATA_W-1:0]      mem_rsp_data;
  logic                   data_wr_en;
  logic [IDX_W+1:0]       data_wr_index;
  logic [DATA_W-1:0]      data_wr_data;
  logic                   flush;
  logic                   resp_valid;
  logic                   resp_hit;
  logic [ADDR_W-1:0]      resp_addr;
  logic [THREAD_W-1:0]    resp_thread;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TAG_W-1:0] tagmem [SETS] = '{default: '0};
  bit               mvalid [SETS];
  logic [TAG_W-1:0] mtag   [SETS];

  typedef struct {
    bit                  timeout, accepted, mem_seen, mem_unstable, flush_sent, aborted, wr_bad;
    int                  acc_cyc, resp_cyc, last_beat_cyc, tw_cyc, beats, tw_cnt;
    logic                rd_en, hit, rst_ready;
    logic [IDX_W-1:0]    rd_idx, tw_idx;
    logic [TAG_W-1:0]    tw_tag;
    logic [ADDR_W-1:0]   mem_addr, resp_addr;
    logic [THREAD_W-1:0] resp_thread;
    logic [3:0][IDX_W+1:0] wr_idx;
    logic [105:0]        rst_vec;
  } obs_t;

  icache_lookup_ctrl dut (
    .clk(clk), .nReset(nReset),
    .req_valid(req_valid), .req_addr(req_addr), .req_thread(req_thread), .req_ready(req_ready),
    .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index), .tag_cmp(tag_cmp),
    .tag_wr_en(tag_wr_en), .tag_wr_index(tag_wr_index), .tag_wr_tag(tag_wr_tag),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .data_wr_en(data_wr_en), .data_wr_index(data_wr_index), .data_wr_data(data_wr_data),
    .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr), .resp_thread(resp_thread)
  );

  always #5 clk = ~clk;

  // Registered, read-before-write tag memory.
  always @(posedge clk) begin
    if (tag_rd_en) tag_cmp <= tagmem[tag_rd_index];
    if (tag_wr_en) tagmem[tag_wr_index] <= tag_wr_tag;
  end

  // Drives one request and services any refill; records what the DUT did.
  task automatic run_req(input logic [ADDR_W-1:0] a, input logic [THREAD_W-1:0] th,
                         input int flush_beat, input int rst_beat, output obs_t o);
    int lat;
    bit granted;
    o = '{default: 0};
    o.timeout = 1;
    granted = 0;
    lat = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      req_valid = !o.accepted; req_addr = a; req_thread = th;
      flush = 1'b0; mem_rsp_valid = 1'b0;
      mem_req_ready = mem_req_valid && (lat == 0);
      if (mem_req_valid && lat > 0) lat--;
      if (granted && o.beats < 4 && $urandom_range(0, 2) != 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
      end
      if (granted && flush_beat == o.beats && !o.flush_sent) begin
        flush = 1'b1; o.flush_sent = 1;
      end
      if (granted && rst_beat == o.beats) begin
        mem_rsp_valid = 1'b0; req_valid = 1'b0;
        nReset = 1'b0;
        #1;
        o.rst_ready = req_ready;
        o.rst_vec = {tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_index, tag_wr_tag,
                     mem_req_valid, mem_req_addr, data_wr_en, data_wr_index, data_wr_data,
                     resp_valid, resp_hit, resp_addr, resp_thread};
        o.aborted = 1; o.timeout = 0;
        @(negedge clk);
        nReset = 1'b1;
        return;
      end
      #1;
      if (!o.accepted && req_ready) begin
        o.accepted = 1; o.acc_cyc = cyc; o.rd_en = tag_rd_en; o.rd_idx = tag_rd_index;
      end
      if (mem_req_valid) begin
        if (o.mem_seen && mem_req_addr !== o.mem_addr) o.mem_unstable = 1;
        o.mem_seen = 1; o.mem_addr = mem_req_addr;
        if (mem_req_ready) granted = 1;
      end
      if (data_wr_en) begin
        if (o.beats < 4) o.wr_idx[o.beats] = data_wr_index;
        if (!mem_rsp_valid || data_wr_data !== mem_rsp_data) o.wr_bad = 1;
        o.beats++; o.last_beat_cyc = cyc;
      end
      if (tag_wr_en) begin
        o.tw_cnt++; o.tw_cyc = cyc; o.tw_idx = tag_wr_index; o.tw_tag = tag_wr_tag;
      end
      if (resp_valid) begin
        o.timeout = 0; o.resp_cyc = cyc; o.hit = resp_hit;
        o.resp_addr = resp_addr; o.resp_thread = resp_thread;
        break;
      end
    end
    req_valid = 1'b0; flush = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [105:0] v;
    #2;
    v = {tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_index, tag_wr_tag,
         mem_req_valid, mem_req_addr, data_wr_en, data_wr_index, data_wr_data,
         resp_valid, resp_hit, resp_addr, resp_thread};
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", v); end
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic test_cold_miss();
    obs_t o;
    run_req(18'h00A34, 2'd2, -1, -1, o);
    n_checks++;
    if (o.timeout) begin n_fail++; $display("FAIL cold_timeout: no response"); return; end
    n_checks++;
    if (o.hit !== 1'b0 || o.resp_thread !== 2'd2 || o.resp_addr !== 18'h00A34) begin
      n_fail++; $display("FAIL cold_resp: got hit %b thr %0d addr %h want 0 2 00a34", o.hit, o.resp_thread, o.resp_addr);
    end
    n_checks++;
    if (o.rd_en !== 1'b1 || o.rd_idx !== 7'h23) begin
      n_fail++; $display("FAIL cold_tag_rd: got en %b idx %h want 1 23", o.rd_en, o.rd_idx);
    end
    n_checks++;
    if (o.mem_addr !== 18'h00A30 || o.mem_unstable) begin
      n_fail++; $display("FAIL cold_mem_addr: got %h unstable %b want 00a30", o.mem_addr, o.mem_unstable);
    end
    n_checks++;
    if (o.beats != 4 || o.wr_bad) begin n_fail++; $display("FAIL cold_beats: got %0d bad %b want 4", o.beats, o.wr_bad); end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (o.wr_idx[b] !== 9'(9'h8C + b)) begin
        n_fail++; $display("FAIL cold_wr_idx%0d: got %h want %h", b, o.wr_idx[b], 9'h8C + b);
      end
    end
    n_checks++;
    if (o.tw_cnt != 1 || o.tw_idx !== 7'h23 || o.tw_tag !== 7'd1 || o.tw_cyc != o.last_beat_cyc + 1) begin
      n_fail++; $display("FAIL cold_tag_wr: got cnt %0d idx %h tag %0d cyc %0d want 1 23 1 %0d",
                         o.tw_cnt, o.tw_idx, o.tw_tag, o.tw_cyc, o.last_beat_cyc + 1);
    end
    n_checks++;
    if (o.resp_cyc != o.last_beat_cyc + 2) begin
      n_fail++; $display("FAIL cold_resp_cyc: got %0d want %0d", o.resp_cyc, o.last_beat_cyc + 2);
    end
    mvalid[7'h23] = 1; mtag[7'h23] = 7'd1;
  endtask

  task automatic test_hit();
    obs_t o;
    run_req(18'h00A38, 2'd1, -1, -1, o);
    n_checks++;
    if (o.timeout || o.hit !== 1'b1 || o.resp_addr !== 18'h00A38 || o.resp_thread !== 2'd1) begin
      n_fail++; $display("FAIL hit_resp: got to %b hit %b addr %h thr %0d want 0 1 00a38 1",
                         o.timeout, o.hit, o.resp_addr, o.resp_thread);
    end
    n_checks++;
    if (o.resp_cyc - o.acc_cyc != 1) begin
      n_fail++; $display("FAIL hit_latency: got %0d want 1", o.resp_cyc - o.acc_cyc);
    end
    n_checks++;
    if (o.mem_seen || o.tw_cnt != 0) begin
      n_fail++; $display("FAIL hit_no_refill: got mem %b tagwr %0d want 0 0", o.mem_seen, o.tw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ea;
    bit exp_v;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = (k < 4); req_addr = 18'h00A30 + 18'(4 * k); req_thread = 2'(k);
      #1;
      if (k < 4) begin
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready); end
      end
      exp_v = (k >= 1 && k <= 4);
      n_checks++;
      if (resp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want %b", k, resp_valid, exp_v); end
      if (exp_v) begin
        ea = 18'h00A30 + 18'(4 * (k - 1));
        n_checks++;
        if (resp_hit !== 1'b1 || resp_addr !== ea || resp_thread !== 2'(k - 1)) begin
          n_fail++; $display("FAIL b2b_resp%0d: got hit %b addr %h thr %0d want 1 %h %0d",
                             k, resp_hit, resp_addr, resp_thread, ea, k - 1);
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_conflict();
    obs_t o;
    run_req(18'h01234, 2'd3, -1, -1, o);
    n_checks++;
    if (o.timeout || o.hit !== 1'b0) begin n_fail++; $display("FAIL conflict_hit: got to %b hit %b want 0 0", o.timeout, o.hit); end
    n_checks++;
    if (o.mem_addr !== 18'h01230) begin n_fail++; $display("FAIL conflict_mem_addr: got %h want 01230", o.mem_addr); end
    n_checks++;
    if (o.tw_tag !== 7'd2 || o.tw_idx !== 7'h23) begin
      n_fail++; $display("FAIL conflict_tag_wr: got tag %0d idx %h want 2 23", o.tw_tag, o.tw_idx);
    end
    mvalid[7'h23] = 1; mtag[7'h23] = 7'd2;
  endtask

  task automatic test_flush_mid_refill();
    obs_t o;
    run_req(18'h00A34, 2'd0, 2, -1, o);
    n_checks++;
    if (o.timeout || o.hit !== 1'b0 || !o.flush_sent || o.beats != 4 || o.tw_tag !== 7'd1) begin
      n_fail++; $display("FAIL flush_refill_done: got to %b hit %b fl %b beats %0d tag %0d want 0 0 1 4 1",
                         o.timeout, o.hit, o.flush_sent, o.beats, o.tw_tag);
    end
    for (int s = 0; s < SETS; s++) mvalid[s] = 0;
    run_req(18'h00A34, 2'd1, -1, -1, o);
    n_checks++;
    if (o.timeout || o.hit !== 1'b0) begin n_fail++; $display("FAIL flush_then_miss: got to %b hit %b want 0 0", o.timeout, o.hit); end
    n_checks++;
    if (o.acc_cyc != 1) begin n_fail++; $display("FAIL flush_cycle_block: got accept cyc %0d want 1", o.acc_cyc); end
    mvalid[7'h23] = 1; mtag[7'h23] = 7'd1;
  endtask

  task automatic test_reset_mid_refill();
    obs_t o;
    run_req(18'h01234, 2'd2, -1, 2, o);
    n_checks++;
    if (!o.aborted || o.rst_ready !== 1'b1 || o.rst_vec !== '0) begin
      n_fail++; $display("FAIL rst_refill_outputs: got ab %b rdy %b vec %h want 1 1 0", o.aborted, o.rst_ready, o.rst_vec);
    end
    for (int s = 0; s < SETS; s++) mvalid[s] = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
      #1;
      n_checks++;
      if (data_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_stray_beat%0d: got %b want 0", k, data_wr_en); end
    end
    mem_rsp_valid = 1'b0;
    run_req(18'h01234, 2'd2, -1, -1, o);
    n_checks++;
    if (o.timeout || o.hit !== 1'b0 || o.beats != 4 || o.wr_idx[0] !== 9'h8C) begin
      n_fail++; $display("FAIL rst_restart: got to %b hit %b beats %0d idx0 %h want 0 0 4 08c",
                         o.timeout, o.hit, o.beats, o.wr_idx[0]);
    end
    mvalid[7'h23] = 1; mtag[7'h23] = 7'd2;
  endtask

  task automatic test_flush_idle();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; req_valid = 1'b1; req_addr = 18'h01234;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || tag_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_block: got ready %b rd %b want 0 0", req_ready, tag_rd_en);
    end
    req_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_after: got %b want 1", req_ready); end
    for (int s = 0; s < SETS; s++) mvalid[s] = 0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [IDX_W-1:0]    pool [3] = '{7'h23, 7'h05, 7'h7F};
    logic [TAG_W-1:0]    t;
    logic [IDX_W-1:0]    ix;
    logic [ADDR_W-1:0]   a;
    logic [THREAD_W-1:0] th;
    bit                  exp_hit;
    int                  fb;
    for (int n = 0; n < 40; n++) begin
      t  = 7'($urandom_range(0, 3));
      ix = pool[$urandom_range(0, 2)];
      a  = {t, ix, 2'($urandom), 2'b00};
      th = 2'($urandom);
      fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      exp_hit = mvalid[ix] && (mtag[ix] == t);
      run_req(a, th, fb, -1, o);
      n_checks++;
      if (o.timeout) begin n_fail++; $display("FAIL rand_timeout: txn %0d addr %h no response", n, a); continue; end
      n_checks++;
      if (o.hit !== exp_hit) begin n_fail++; $display("FAIL rand_hit: txn %0d addr %h got %b want %b", n, a, o.hit, exp_hit); end
      n_checks++;
      if (o.resp_addr !== a || o.resp_thread !== th) begin
        n_fail++; $display("FAIL rand_id: txn %0d got %h/%0d want %h/%0d", n, o.resp_addr, o.resp_thread, a, th);
      end
      if (exp_hit) begin
        n_checks++;
        if (o.resp_cyc - o.acc_cyc != 1) begin
          n_fail++; $display("FAIL rand_hit_lat: txn %0d got %0d want 1", n, o.resp_cyc - o.acc_cyc);
        end
      end else begin
        n_checks++;
        if (o.mem_addr !== {a[ADDR_W-1:4], 4'b0000} || o.mem_unstable || o.beats != 4 || o.wr_bad) begin
          n_fail++; $display("FAIL rand_refill: txn %0d got addr %h beats %0d want %h 4", n, o.mem_addr, o.beats, {a[ADDR_W-1:4], 4'b0000});
        end
        for (int b = 0; b < 4; b++) begin
          n_checks++;
          if (o.wr_idx[b] !== {ix, 2'(b)}) begin
            n_fail++; $display("FAIL rand_wr_idx: txn %0d beat %0d got %h want %h", n, b, o.wr_idx[b], {ix, 2'(b)});
          end
        end
        n_checks++;
        if (o.tw_cnt != 1 || o.tw_idx !== ix || o.tw_tag !== t || o.resp_cyc != o.last_beat_cyc + 2) begin
          n_fail++; $display("FAIL rand_update: txn %0d got %0d %h %0d cyc %0d want 1 %h %0d cyc %0d",
                             n, o.tw_cnt, o.tw_idx, o.tw_tag, o.resp_cyc, ix, t, o.last_beat_cyc + 2);
        end
        mvalid[ix] = 1; mtag[ix] = t;
      end
      if (o.flush_sent) for (int s = 0; s < SETS; s++) mvalid[s] = 0;
    end
  endtask

  initial begin
    nReset = 1'b0; req_valid = 1'b0; req_addr = '0; req_thread = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; flush = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush_mid_refill();
    test_reset_mid_refill();
    test_flush_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/icache_lookup_ctrl.md
Name: icache_lookup_ctrl

Overview:
Instruction-cache lookup and refill controller that sits directly in front of the instruction tag memory.
- Accepts fetch requests tagged with a thread ID.
- Drives the tag memory read port and compares the returned tag against the request.
- Owns the per-set valid bits.
- On a miss, runs a 4-beat line refill from memory, writes the data array and then the tag memory, and reports completion to fetch.

Parameters:
- ADDR_W, 18, fetch byte-address width: tag [17:11], index [10:4], word [3:2], byte [1:0]
- TAG_W, 7, tag width; must match the tag memory
- IDX_W, 7, set index width; SETS = 2**IDX_W = 128
- WORDS, 4, 32-bit words per line
- DATA_W, 32, memory beat width
- THREAD_W, 2, thread ID width

Ports:
- clk, in, 1, clock
- nReset, in, 1, asynchronous active-low reset
- req_valid, in, 1, fetch request valid
- req_addr, in, ADDR_W, fetch byte address
- req_thread, in, THREAD_W, requesting thread
- req_ready, out, 1, request accepted when req_valid && req_ready
- tag_rd_en, out, 1, tag memory read enable (Enable)
- tag_rd_index, out, IDX_W, tag memory read index (CacheIndexRead)
- tag_cmp, in, TAG_W, registered tag memory output (TagCompare), valid 1 cycle after tag_rd_en
- tag_wr_en, out, 1, tag write (WriteTag)
- tag_wr_index, out, IDX_W, tag write index (CacheIndexWrite)
- tag_wr_tag, out, TAG_W, tag written (WriteAddressTag)
- mem_req_valid, out, 1, line fetch request
- mem_req_addr, out, ADDR_W, line-aligned address ({tag, index, 4'b0})
- mem_req_ready, in, 1, memory accepts request
- mem_rsp_valid, in, 1, refill beat valid
- mem_rsp_data, in, DATA_W, refill beat
- data_wr_en, out, 1, data array write
- data_wr_index, out, IDX_W+2, {index, beat}
- data_wr_data, out, DATA_W, beat data (mem_rsp_data passthrough)
- flush, in, 1, invalidate all sets (pulse)
- resp_valid, out, 1, one pulse per accepted request
- resp_hit, out, 1, 1 = hit, 0 = serviced by refill
- resp_addr, out, ADDR_W, address of the request being answered
- resp_thread, out, THREAD_W, thread of the request being answered

Behaviour:
- Reset (async, nReset = 0):
  - State goes to IDLE; all 128 valid bits, the beat counter and flush_pending clear.
  - All outputs are 0 except req_ready, which is 1 (IDLE, no flush pending).
  - Memory beats arriving after reset in a state other than REFILL are ignored.
- States: IDLE, COMPARE, MEM_REQ, REFILL, UPDATE, RESP.
- Accept:
  - req_ready = !flush_pending && (IDLE || (COMPARE && hit)).
  - On accept, tag_rd_en = 1 and tag_rd_index = req_addr index in the same cycle; addr and thread are registered; next state is COMPARE.
- COMPARE:
  - hit = valid[idx] && (tag_cmp == reg_tag).
  - Hit: resp_valid = 1 and resp_hit = 1 this cycle (combinational from registered request). Go to COMPARE if a new request is accepted, else IDLE. Back-to-back hits sustain 1 response per cycle.
  - Miss: go to MEM_REQ, with no response this cycle.
- MEM_REQ: hold mem_req_valid = 1 and a stable mem_req_addr until mem_req_ready; then REFILL with beat = 0.
- REFILL:
  - Each mem_rsp_valid: data_wr_en = 1, data_wr_index = {idx, beat}, then beat++.
  - On beat 3 go to UPDATE. Gaps between beats are allowed.
- UPDATE: tag_wr_en = 1, tag_wr_index = idx, tag_wr_tag = reg_tag, and valid[idx] is set at the clock edge.
- RESP: resp_valid = 1, resp_hit = 0; then IDLE. A miss costs 1 + 1 + (memory latency) + 4 + 1 + 1 cycles minimum.
- Flush:
  - A flush pulse in any state sets flush_pending.
  - All valid bits clear on the first IDLE cycle with flush_pending, and flush_pending clears in that cycle; no request is accepted in it.
  - A refill in progress completes and responds first; its set is then invalidated by the flush.
- Read-after-write hazard: the tag memory is read-before-write. No read is issued in UPDATE, so a following request to the same index sees the new tag.
- Exactly one response per accepted request, in acceptance order (a single request is outstanding, apart from the hit overlap).

Decomposition:
- Package icache_pkg holds:
  - the state enum;
  - ADDR_W / TAG_W / IDX_W / WORDS constants;
  - functions get_tag(addr), get_idx(addr) and line_addr(addr).
- Sub-module icache_valid_array holds the 128 valid flops:
  - async clear on reset;
  - synchronous clear_all;
  - set(index);
  - combinational read(index).

Test Plan:
- Cold miss, req_addr = 0x00A34, thread 2 -> mem_req_addr = 0x00A30; after 4 beats data_wr_index = 0x8C..0x8F; tag_wr_en with index 0x23, tag 1; then resp_valid, resp_hit = 0, resp_thread = 2.
- Repeat 0x00A38 after that refill, with tag memory returning 1 -> resp_hit = 1 exactly 1 cycle after accept.
- Four back-to-back hits to the refilled line -> req_ready stays high and 4 resp pulses arrive on consecutive cycles.
- Conflict: tag_cmp = 1 but request 0x01234 (tag 2, idx 0x23) -> miss; mem_req_addr = 0x01230; tag_wr_tag = 2.
- Flush pulse mid-REFILL -> the refill completes and responds, then the next request to 0x00A34 misses.
- nReset asserted during REFILL beat 2 -> outputs go to 0 immediately; the next request to the same line misses and restarts at beat 0.
